jt900h_dump_rd: RTL
===================

// Module: jt900h_dump_rd
// PURPOSE
// - Reader end of the jt900h register-dump port: halts the CPU, walks dmp_addr over the dump map and captures dmp_din.
// - Emits each captured byte on a valid/ready byte stream (UART bridge, debug FIFO, or bench sink).
// - Sits beside jt900h at system top level and gates the CPU clock enable for the duration of a dump.
// PARAMETERS
// - LEN   84   number of dump bytes read, addresses 0..LEN-1 (64 GP bytes, 16 index-reg bytes, SR, pad)
// - AW     8   width of dmp_addr; LEN <= 2**AW
// PORTS
// - clk       in   1   system clock, single clock domain
// - rst       in   1   asynchronous reset, active-low (asserted at 0)
// - cen_in    in   1   system clock enable for the CPU
// - cpu_cen   out  1   clock enable to jt900h = cen_in & ~halt
// - start     in   1   one-cycle request to begin a dump
// - busy      out  1   high from accepted start until done
// - done      out  1   one-cycle pulse after the final byte handshake
// - dmp_addr  out  AW  dump address to jt900h
// - dmp_din   in   8   dump data from jt900h; registered, valid 1 clk after dmp_addr
// - tx_data   out  8   captured byte
// - tx_valid  out  1   tx_data valid
// - tx_ready  in   1   sink accepts when tx_valid & tx_ready at posedge
// - tx_last   out  1   high with the byte from address LEN-1
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; dmp_addr=0, tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, halt=0.
// - FSM states: IDLE, HALT, ADDR, CAPT, SEND, FIN. The FSM advances every clk; cen_in does not gate it.
//   - IDLE: start=1 -> HALT, halt<=1, busy<=1, dmp_addr<=0.
//   - HALT: one settle cycle so the CPU is frozen -> ADDR.
//   - ADDR: dmp_addr stable -> CAPT.
//   - CAPT: tx_data<=dmp_din, tx_valid<=1, tx_last<=(dmp_addr==LEN-1) -> SEND.
//   - SEND: hold tx_data/tx_last while tx_valid & !tx_ready.
//     On handshake: tx_valid<=0; if tx_last -> FIN, else dmp_addr<=dmp_addr+1 -> ADDR.
//   - FIN: done=1 for one cycle, halt<=0, busy<=0, dmp_addr<=0 -> IDLE.
// - Latency:
//   - start -> first tx_valid is 4 clk (HALT, ADDR, CAPT, then valid).
//   - With tx_ready held at 1, each byte takes 3 clk. A full dump takes 3*LEN+3 clk.
// - cpu_cen is 0 while halt=1. halt rises on the clk edge that accepts start and falls on the FIN edge.
//   Outside a dump, cpu_cen tracks cen_in combinationally.
// - start while busy is ignored. start in the same cycle as FIN is ignored; the next start is accepted from IDLE.
// - dmp_addr never exceeds LEN-1 and does not wrap mid-dump. The address counter is AW bits; LEN=2**AW is legal.
// - tx_ready asserted without tx_valid has no effect. tx_valid never drops without a handshake.
// - Reset mid-dump: immediate return to reset values, so cpu_cen=cen_in and the CPU resumes.
//   A partial stream ends without tx_last.
// STRUCTURE
// - Shared package jt900h_dbg_pkg:
//   - constants DUMP_LEN=84, DUMP_IDX_OFS=64, DUMP_SR_OFS=80;
//   - state enum encoding, shared with the future dump writer.
// - Single flat module with no sub-module. The byte stream port matches jt900h_dbg_uart_tx for direct hookup.
// TESTING
// - Reset then start with tx_ready=1:
//   84 bytes emitted in address order, tx_last only on byte 83, done 255 clk after start, cpu_cen=0 throughout.
// - Dump model returns {addr ^ 8'h5A}: every tx_data equals addr^5A.
//   Byte 80 maps to SR low and byte 81 to SR high, matching the packing order.
// - tx_ready random 30% duty:
//   tx_data/tx_last stable while stalled, no byte lost or duplicated, 84 handshakes total.
// - start pulsed again at byte 10 and in the FIN cycle:
//   both ignored, single 84-byte stream, busy stays high until done.
// - rst=0 asserted while dmp_addr=40:
//   all outputs reset asynchronously, cpu_cen follows cen_in.
//   A new start afterwards restarts at address 0.
// - cen_in toggling every clk:
//   dump timing unchanged, cpu_cen=0 during dump, cpu_cen==cen_in before start and after done.

Source files
------------

// File: rtl/jt900h_dbg_pkg.sv
// Shared definitions for the jt900h register-dump reader and the future dump writer.
// The dump map is 64 GP bytes, 16 index-register bytes, then SR low/high and padding.
package jt900h_dbg_pkg;

    localparam int DUMP_LEN     = 84;
    localparam int DUMP_IDX_OFS = 64;
    localparam int DUMP_SR_OFS  = 80;

    // Encoding is shared with the writer side, so keep the order stable
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HALT = 3'd1,
        ST_ADDR = 3'd2,
        ST_CAPT = 3'd3,
        ST_SEND = 3'd4,
        ST_FIN  = 3'd5
    } dump_state_e;

endpackage

// File: rtl/jt900h_dump_rd.sv
// Dump reader: freezes jt900h through cpu_cen, walks dmp_addr over the dump map
// and streams every captured byte out on a valid/ready byte port.
module jt900h_dump_rd
    import jt900h_dbg_pkg::*;
#(
    parameter int LEN = DUMP_LEN,
    parameter int AW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen_in,
    output logic          cpu_cen,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] dmp_addr,
    input  logic [7:0]    dmp_din,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          tx_last
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);

    dump_state_e state, state_nx;
    logic        halt;

    assign cpu_cen = cen_in & ~halt;

    // Next-state logic; done is a Moore output of the FIN state
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nx = ST_HALT;
            ST_HALT: state_nx = ST_ADDR;
            ST_ADDR: state_nx = ST_CAPT;
            ST_CAPT: state_nx = ST_SEND;
            ST_SEND: if (tx_ready) state_nx = tx_last ? ST_FIN : ST_ADDR;
            ST_FIN: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath: the address only advances on a non-final handshake, so it never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmp_addr <= '0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            halt     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        halt     <= 1'b1;
                        busy     <= 1'b1;
                        dmp_addr <= '0;
                    end
                end
                ST_CAPT: begin
                    tx_data  <= dmp_din;
                    tx_valid <= 1'b1;
                    tx_last  <= (dmp_addr == LAST_ADDR);
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        if (!tx_last) dmp_addr <= dmp_addr + 1'b1;
                    end
                end
                ST_FIN: begin
                    halt     <= 1'b0;
                    busy     <= 1'b0;
                    dmp_addr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
